// File: rtl/vreg_port_sequencer.sv
// vreg_port_sequencer: steps one vector-register read or write command through
// a shared crossbar port, one element at a time, retrying any request that
// loses arbitration (no grant on the cycle after it was issued).
// Optional feature: define VREG_SEQ_TIMEOUT_EN to bound consecutive lost
// attempts at RETRY_LIMIT; the command is then dropped with an err pulse.
// Without it, retries are unbounded and err is tied low.
`timescale 1ns/1ps
module vreg_port_sequencer #(
    parameter int NUM_OF_VECTOR_REG = 32,
    parameter int VECTOR_REG_DEPTH  = 64,
    parameter int VECTOR_REG_WIDTH  = 64,
    parameter int RETRY_LIMIT       = 255,
    localparam int AW  = $clog2(VECTOR_REG_DEPTH),
    localparam int RPW = $clog2(NUM_OF_VECTOR_REG)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic                        cmd_write,
    input  logic [RPW-1:0]              cmd_reg,
    input  logic [AW-1:0]               cmd_base,
    input  logic [AW:0]                 cmd_len,
    input  logic                        wr_vld,
    input  logic [VECTOR_REG_WIDTH-1:0] wr_data,
    output logic                        wr_rdy,
    output logic                        rd_vld,
    output logic [VECTOR_REG_WIDTH-1:0] rd_data,
    output logic                        req_vld,
    output logic                        req_write,
    output logic [RPW-1:0]              req_reg_ptr,
    output logic [AW-1:0]               req_addr,
    output logic [VECTOR_REG_WIDTH-1:0] req_data,
    input  logic                        rsp_vld,
    input  logic [VECTOR_REG_WIDTH-1:0] reg_rd_data,
    output logic                        done,
    output logic                        err
);

    localparam int IW = AW + 1;

    if (RETRY_LIMIT < 1) begin : g_cfg_chk
        $error("RETRY_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic             cmd_rdy_q;
    logic             write_q;
    logic [RPW-1:0]   reg_q;
    logic [AW-1:0]    base_q;
    logic [AW:0]      len_q;
    logic [AW:0]      idx;
    logic [AW:0]      idx_nxt;
    logic [AW-1:0]    elem_addr;
    logic             grant;

`ifdef VREG_SEQ_TIMEOUT_EN
    localparam int RW = $clog2(RETRY_LIMIT + 1);
    logic [RW-1:0]    retry_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Element address wraps inside the register (AW-bit add drops the carry).
    assign elem_addr = base_q + idx[AW-1:0];
    assign idx_nxt   = idx + IW'(1);

    // A grant only means something while a request is outstanding.
    assign grant = (state == WAIT) && rsp_vld;

    // Writes hold off issuing until the element stream has data.
    assign req_vld     = (state == ISSUE) && (!write_q || wr_vld);
    assign req_write   = req_vld && write_q;
    assign req_reg_ptr = req_vld ? reg_q : '0;
    assign req_addr    = req_vld ? elem_addr : '0;
    assign req_data    = req_write ? wr_data : '0;

    // Write data is popped only on grant, so a retried element resends the
    // same word; reads pass the register file data straight through.
    assign wr_rdy  = grant && write_q;
    assign rd_vld  = grant && !write_q;
    assign rd_data = rd_vld ? reg_rd_data : '0;

    assign cmd_rdy = cmd_rdy_q;
    assign done    = (state == DONE);

    // Command sequencing: accept, issue/wait per element, retry on lost grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_rdy_q <= 1'b0;
            write_q   <= 1'b0;
            reg_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
`ifdef VREG_SEQ_TIMEOUT_EN
            retry_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef VREG_SEQ_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy_q) begin
                        cmd_rdy_q <= 1'b0;
                        write_q   <= cmd_write;
                        reg_q     <= cmd_reg;
                        base_q    <= cmd_base;
                        len_q     <= cmd_len;
                        idx       <= '0;
`ifdef VREG_SEQ_TIMEOUT_EN
                        retry_cnt <= '0;
`endif
                        state     <= (cmd_len == '0) ? DONE : ISSUE;
                    end else begin
                        cmd_rdy_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (req_vld) state <= WAIT;
                end
                WAIT: begin
                    if (rsp_vld) begin
                        idx   <= idx_nxt;
`ifdef VREG_SEQ_TIMEOUT_EN
                        retry_cnt <= '0;
`endif
                        state <= (idx_nxt == len_q) ? DONE : ISSUE;
                    end else begin
`ifdef VREG_SEQ_TIMEOUT_EN
                        if (32'(retry_cnt) + 1 >= RETRY_LIMIT) begin
                            err_q     <= 1'b1;
                            cmd_rdy_q <= 1'b1;
                            retry_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                DONE: begin
                    cmd_rdy_q <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vreg_port_sequencer.sv
// Bench for vreg_port_sequencer: a crossbar responder with programmable
// denials, a write element source, a transaction-level model that checks
// every cycle, and directed commands with hand-computed expectations.
`timescale 1ns/1ps
module tb_vreg_port_sequencer;

    localparam int NR = 32, DEPTH = 64, W = 64, RL = 3;
    localparam int AW = 6, RPW = 5, LW = AW + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_vld = 1'b0, cmd_write = 1'b0;
    logic [RPW-1:0] cmd_reg = '0;
    logic [AW-1:0]  cmd_base = '0;
    logic [AW:0]    cmd_len = '0;
    logic wr_vld = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic rsp_vld = 1'b0;
    logic [W-1:0] reg_rd_data = '0;
    logic cmd_rdy, wr_rdy, rd_vld, req_vld, req_write, done, err;
    logic [W-1:0] rd_data, req_data;
    logic [RPW-1:0] req_reg_ptr;
    logic [AW-1:0] req_addr;

    vreg_port_sequencer #(.NUM_OF_VECTOR_REG(NR), .VECTOR_REG_DEPTH(DEPTH),
                          .VECTOR_REG_WIDTH(W), .RETRY_LIMIT(RL)) dut (
        .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .req_vld(req_vld), .req_write(req_write), .req_reg_ptr(req_reg_ptr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_vld(rsp_vld), .reg_rd_data(reg_rd_data), .done(done), .err(err));

    always #5 clk = ~clk;

    int ntests = 0, nfail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        ntests++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Register file contents seen through the crossbar, and the write stream.
    function automatic logic [W-1:0] mem_word(int r, int a);
        return {16'hBEEF, 8'(r), 8'(a), 32'(r * 1000 + a)};
    endfunction
    function automatic logic [W-1:0] wdat(int k);
        return 64'h5A5A_0000_0000_0000 + 64'(k) * 64'h0000_0001_0000_0003;
    endfunction

    // Crossbar responder: grants a request on the following cycle unless
    // 'deny' still has lost attempts to hand out; force_rsp injects stray grants.
    int deny = 0;
    bit force_rsp = 0;
    initial begin
        bit g;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            g = 0;
            d = 64'hDEAD_0000_0000_0000 + 64'(cyc);
            if (req_vld) begin
                if (deny > 0) deny--;
                else begin
                    g = 1;
                    d = mem_word(int'(req_reg_ptr), int'(req_addr));
                end
            end
            if (force_rsp) g = 1;
            @(posedge clk); #1;
            rsp_vld = g;
            reg_rd_data = d;
        end
    end

    // Write source: next element appears after each wr_rdy.
    // wr_mode 0 = idle, 1 = always valid, 2 = valid two cycles out of three.
    int wr_mode = 0, w_idx = 0;
    initial forever begin
        @(negedge clk);
        if (reset && wr_rdy) w_idx++;
        @(posedge clk); #1;
        wr_data = wdat(w_idx);
        wr_vld  = (wr_mode == 1) || (wr_mode == 2 && (cyc % 3) != 1);
    end

    // Transaction-level model: command in flight, elements completed, and
    // whether a request went out last cycle (so a grant is due now).
    bit busy = 0, outst = 0, done_due = 0, err_due = 0, m_write = 0;
    int settle = 1, m_reg, m_base, m_len, m_beats, m_retry, m_wcnt = 0;
    int s_nreq = 0, s_nrd = 0, s_nwr = 0, s_acc_cyc = 0, s_done_cyc = 0;
    int s_addr[$];
    int n_done = 0, n_err = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            busy = 0; outst = 0; done_due = 0; err_due = 0; settle = 1;
        end else begin
            if (settle > 0) settle--;
            else chk("cmd_rdy", cmd_rdy, !busy);
            chk("done", done, done_due);
            chk("err", err, err_due);
            if (done) begin n_done++; s_done_cyc = cyc; end
            if (err) n_err++;
            if (done_due) busy = 0;
            done_due = 0;
            err_due = 0;
            if (outst) begin
                chk("req_gap", req_vld, 0);
                if (rsp_vld) begin
                    chk("wr_rdy", wr_rdy, m_write);
                    chk("rd_vld", rd_vld, !m_write);
                    if (!m_write) begin
                        chk("rd_data", rd_data, mem_word(m_reg, (m_base + m_beats) % DEPTH));
                        s_nrd++;
                    end else begin
                        m_wcnt++;
                        s_nwr++;
                    end
                    m_beats++;
                    m_retry = 0;
                    if (m_beats == m_len) done_due = 1;
                end else begin
                    chk("wr_rdy", wr_rdy, 0);
                    chk("rd_vld", rd_vld, 0);
                    m_retry++;
`ifdef VREG_SEQ_TIMEOUT_EN
                    if (m_retry >= RL) begin err_due = 1; busy = 0; end
`endif
                end
            end else begin
                chk("wr_rdy", wr_rdy, 0);
                chk("rd_vld", rd_vld, 0);
            end
            if (req_vld) begin
                chk("req_busy", busy && (m_beats < m_len), 1);
                chk("req_addr", req_addr, (m_base + m_beats) % DEPTH);
                chk("req_reg", req_reg_ptr, m_reg);
                chk("req_write", req_write, m_write);
                if (m_write) begin
                    chk("req_data", req_data, wdat(m_wcnt));
                    chk("wr_vld", wr_vld, 1);
                end
                s_nreq++;
                s_addr.push_back(int'(req_addr));
            end
            outst = req_vld;
            if (cmd_vld && cmd_rdy) begin
                busy = 1; m_write = cmd_write; m_reg = int'(cmd_reg);
                m_base = int'(cmd_base); m_len = int'(cmd_len);
                m_beats = 0; m_retry = 0;
                s_nreq = 0; s_nrd = 0; s_nwr = 0; s_addr.delete(); s_acc_cyc = cyc;
                if (m_len == 0) done_due = 1;
            end
        end
    end

    // Step to just after a falling edge so the model has been updated.
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic start_cmd(input bit wr, input int r, input int b, input int l);
        int t;
        t = 0;
        @(posedge clk); #1;
        cmd_vld = 1; cmd_write = wr; cmd_reg = RPW'(r); cmd_base = AW'(b); cmd_len = LW'(l);
        do begin @(negedge clk); t++; end while (!cmd_rdy && t < 50);
        if (!cmd_rdy) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_vld = 0;
    endtask

    task automatic wait_end(input int budget);
        int d0, e0, t;
        d0 = n_done; e0 = n_err; t = 0;
        while (n_done == d0 && n_err == e0 && t < budget) begin tick(); t++; end
        if (n_done == d0 && n_err == e0) chk("end_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #1 reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_outs", {req_vld, wr_rdy, rd_vld, done, err}, 0);
        chk("rst_data", req_addr | req_data | rd_data | W'(req_reg_ptr), 0);
        reset = 1;
        repeat (2) tick();
        chk("rdy_after_rel", cmd_rdy, 1);

        // Read reg 5, base 0, len 4, immediate grants.
        start_cmd(0, 5, 0, 4);
        wait_end(100);
        chk("t1_nrd", s_nrd, 4);
        chk("t1_addr0", s_addr[0], 0);
        chk("t1_addr3", s_addr[3], 3);
        chk("t1_done_edges", s_done_cyc - s_acc_cyc - 1, 8);

        // Write reg 2, base 62, len 4: address wraps 62,63,0,1.
        wr_mode = 1;
        start_cmd(1, 2, 62, 4);
        wait_end(100);
        chk("t2_nwr", s_nwr, 4);
        chk("t2_addr0", s_addr[0], 62);
        chk("t2_addr1", s_addr[1], 63);
        chk("t2_addr2", s_addr[2], 0);
        chk("t2_addr3", s_addr[3], 1);
        wr_mode = 0;

        // Read len 3, first two attempts lose arbitration.
        deny = 2;
        start_cmd(0, 7, 0, 3);
        wait_end(100);
        chk("t3_nreq", s_nreq, 5);
        chk("t3_retry_addr", s_addr[0] + s_addr[1] + s_addr[2], 0);
        chk("t3_nrd", s_nrd, 3);

        // Zero length: no request, done in the cycle after accept.
        start_cmd(0, 1, 9, 0);
        wait_end(20);
        chk("t4_nreq", s_nreq, 0);
        chk("t4_done_lat", s_done_cyc - s_acc_cyc, 1);

        // Write with a gappy element stream and one lost attempt.
        wr_mode = 2; deny = 1;
        start_cmd(1, 31, 10, 5);
        wait_end(200);
        chk("t5_nwr", s_nwr, 5);
        chk("t5_nreq", s_nreq, 6);
        chk("t5_retry_addr", s_addr[1], 10);
        chk("t5_last_addr", s_addr[5], 14);
        wr_mode = 0;

        // Full-depth read starting mid-register.
        start_cmd(0, 12, 17, 64);
        wait_end(400);
        chk("t6_nrd", s_nrd, 64);
        chk("t6_addr46", s_addr[46], 63);
        chk("t6_addr47", s_addr[47], 0);
        chk("t6_addr63", s_addr[63], 16);

        // Stray grants while idle must not produce read beats.
        force_rsp = 1;
        repeat (3) begin tick(); chk("t7_stray_rd", rd_vld, 0); end
        force_rsp = 0;
        tick();

`ifdef VREG_SEQ_TIMEOUT_EN
        // Never granted: abort after RETRY_LIMIT attempts, err but no done.
        begin
            int d0, e0;
            d0 = n_done; e0 = n_err;
            deny = 1000;
            start_cmd(0, 4, 33, 2);
            wait_end(100);
            deny = 0;
            chk("t8_nreq", s_nreq, 3);
            chk("t8_err", n_err - e0, 1);
            chk("t8_no_done", n_done, d0);
            chk("t8_rdy", cmd_rdy, 1);
        end
`else
        // Without the timeout, retries continue until a grant arrives.
        begin
            int e0;
            e0 = n_err;
            deny = 20;
            start_cmd(0, 4, 33, 1);
            wait_end(200);
            chk("t8_nreq", s_nreq, 21);
            chk("t8_nrd", s_nrd, 1);
            chk("t8_no_err", n_err, e0);
        end
`endif

        // Reset during the wait of element 2: silent abort.
        begin
            int d0, t;
            start_cmd(0, 3, 8, 4);
            t = 0;
            while (s_nreq < 2 && t < 50) begin tick(); t++; end
            chk("t9_setup", s_nreq, 2);
            d0 = n_done;
            @(posedge clk); #1;
            reset = 0;
            #1;
            chk("t9_outs", {cmd_rdy, req_vld, wr_rdy, rd_vld, done, err}, 0);
            chk("t9_data", req_addr | req_data | rd_data | W'(req_reg_ptr), 0);
            repeat (2) @(posedge clk);
            #1 reset = 1;
            repeat (4) tick();
            chk("t9_no_done", n_done, d0);
            chk("t9_rdy", cmd_rdy, 1);
        end

        // Normal operation after the aborted command.
        start_cmd(0, 9, 60, 2);
        wait_end(100);
        chk("t10_nrd", s_nrd, 2);
        chk("t10_addr1", s_addr[1], 61);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
